// File: rtl/playback_buffer_if.sv
// Load (DMA write) and playback (DAC stream) signals of the playback buffer.
interface playback_buffer_if #(
  parameter int unsigned DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_valid;
  logic                  load_last;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] playback_data;
  logic                  playback_valid;

  modport master (
    output load_data, load_valid, load_last,
    input  load_ready, playback_data, playback_valid
  );

  modport slave (
    input  load_data, load_valid, load_last,
    output load_ready, playback_data, playback_valid
  );
endinterface

// File: rtl/playback_buffer.sv
// Transmit-side waveform buffer: loads one waveform from DMA into block RAM,
// then streams it to the DAC one word per cycle, looped burst_count times.
module playback_buffer #(
  parameter int unsigned BUFFER_DEPTH = 256,
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  playback_buffer_if.slave                bus,
  input  logic                            sw_reset,
  input  logic                            sw_start,
  input  logic                            sw_stop,
  input  logic                            hw_start,
  input  logic [15:0]                     burst_count,
  output logic [$clog2(BUFFER_DEPTH):0]   loaded_depth,
  output logic                            load_overflow,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW = AW + 1;
  // RAM output register plus intermediate stages; the last stage is the output register
  localparam int unsigned PS = READ_LATENCY - 1;

  typedef enum logic [1:0] {IDLE, LOADING, ARMED, PLAYING} state_t;
  state_t state, state_d;

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [DATA_WIDTH-1:0] dat [PS];
  logic [PS-1:0]         vld;
  logic [CW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [15:0]           loop_cnt;
  logic [15:0]           latched_burst;
  logic                  issue_done;
  logic                  load_ready_q;
  logic                  pb_valid_q;
  logic [DATA_WIDTH-1:0] pb_data_q;

  logic accept, finish_load, set_ovf, start_play, rd_en, stop_play, drain_done;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    finish_load = 1'b0;
    set_ovf     = 1'b0;
    start_play  = 1'b0;
    rd_en       = 1'b0;
    stop_play   = 1'b0;
    drain_done  = 1'b0;
    case (state)
      IDLE, LOADING: begin
        if (bus.load_valid) begin
          accept = 1'b1;
          if (bus.load_last || wr_ptr == CW'(BUFFER_DEPTH - 1)) begin
            finish_load = 1'b1;
            set_ovf     = ~bus.load_last;
            state_d     = ARMED;
          end else begin
            state_d = LOADING;
          end
        end
      end
      ARMED: begin
        if ((sw_start | hw_start) & ~sw_stop) begin
          start_play = 1'b1;
          state_d    = PLAYING;
        end
      end
      PLAYING: begin
        rd_en = ~issue_done;
        if (sw_stop) begin
          stop_play = 1'b1;
          state_d   = ARMED;
        end else if (issue_done && vld == '0) begin
          // final word sits in the output register this cycle
          drain_done = 1'b1;
          state_d    = ARMED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sw_reset) begin
      state_d     = IDLE;
      accept      = 1'b0;
      finish_load = 1'b0;
      set_ovf     = 1'b0;
      start_play  = 1'b0;
      rd_en       = 1'b0;
      stop_play   = 1'b0;
      drain_done  = 1'b0;
    end
  end

  // Block RAM and read data pipeline, no reset so the RAM maps to BRAM
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= bus.load_data;
    dat[0] <= mem[rd_ptr];
    for (int i = 1; i < int'(PS); i++) dat[i] <= dat[i-1];
  end

  always_ff @(posedge clk) begin
    if (reset || sw_reset) begin
      wr_ptr        <= '0;
      loaded_depth  <= '0;
      load_overflow <= 1'b0;
      rd_ptr        <= '0;
      loop_cnt      <= '0;
      latched_burst <= '0;
      issue_done    <= 1'b0;
      vld           <= '0;
      pb_valid_q    <= 1'b0;
      pb_data_q     <= '0;
      done          <= 1'b0;
      busy          <= 1'b0;
      load_ready_q  <= 1'b1;
    end else begin
      load_ready_q <= (state_d == IDLE) || (state_d == LOADING);
      busy         <= (state_d == PLAYING);
      done         <= drain_done | stop_play;

      if (accept)      wr_ptr        <= wr_ptr + CW'(1);
      if (finish_load) loaded_depth  <= wr_ptr + CW'(1);
      if (set_ovf)     load_overflow <= 1'b1;

      if (start_play) begin
        rd_ptr        <= '0;
        loop_cnt      <= '0;
        latched_burst <= burst_count;
        issue_done    <= 1'b0;
      end else if (rd_en) begin
        if (rd_ptr == AW'(loaded_depth - CW'(1))) begin
          rd_ptr   <= '0;
          loop_cnt <= loop_cnt + 16'd1;
          // burst of zero never terminates on its own
          if (latched_burst != 16'd0 && loop_cnt == latched_burst - 16'd1) issue_done <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end

      if (stop_play) begin
        vld        <= '0;
        pb_valid_q <= 1'b0;
        pb_data_q  <= '0;
      end else begin
        vld[0] <= rd_en;
        for (int i = 1; i < int'(PS); i++) vld[i] <= vld[i-1];
        pb_valid_q <= vld[PS-1];
        pb_data_q  <= vld[PS-1] ? dat[PS-1] : '0;
      end
    end
  end

  assign bus.load_ready     = load_ready_q;
  assign bus.playback_valid = pb_valid_q;
  assign bus.playback_data  = pb_data_q;

endmodule
